// File: rtl/pmu_tx_pkg.sv
// Shared definitions for the PMU serial configuration port: FSM states and frame patterns.
// Used by the host transmitter, the PMU receiver and benches.
package pmu_tx_pkg;

  localparam int unsigned HDR_LEN = 12;
  localparam int unsigned FTR_LEN = 5;
  // Wide enough for the header, footer and any NOP gap up to 256 cycles.
  localparam int unsigned CNT_W   = 8;

  // Bit 0 of each pattern goes on the wire first.
  localparam logic [HDR_LEN-1:0] TMS_HDR = 12'b011000000110;
  localparam logic [HDR_LEN-1:0] TDI_HDR = 12'b001101100000;
  localparam logic [FTR_LEN-1:0] TMS_FTR = 5'b11111;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StNop,
    StFooter
  } tx_state_e;

endpackage

// File: rtl/pmu_tx_shifter.sv
// Payload word register: parallel load, LSB-first serial out, bit counter and last-bit flag.
// With PMU_TX_TDO_CAPTURE_EN defined it also collects td_i into rx_word_o, LSB-first.
module pmu_tx_shifter #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
`ifdef PMU_TX_TDO_CAPTURE_EN
  input  logic              cap_en_i,
  input  logic              td_i,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
`endif
  output logic              bit_next_o,
  output logic              bit_last_o
);

  localparam int unsigned      BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bit that will be on the wire next cycle, so the caller can register it.
  assign bit_next_o = shreg_d[0];
  assign bit_last_o = (cnt_q == BIT_LAST);

`ifdef PMU_TX_TDO_CAPTURE_EN
  logic [WORD_W-1:0] rx_sh_q;
  logic [WORD_W-1:0] rx_word_q;
  logic              rx_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sh_q    <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (cap_en_i) begin
        rx_sh_q <= {td_i, rx_sh_q[WORD_W-1:1]};
        if (bit_last_o) begin
          rx_word_q  <= {td_i, rx_sh_q[WORD_W-1:1]};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign rx_word_o  = rx_word_q;
  assign rx_valid_o = rx_valid_q;
`endif

endmodule

// File: rtl/pmu_jtag_stream_tx.sv
// Host-side PMU configuration transmitter: frames valid/ready payload words into a TMS/TDI stream.
// Optional TDO capture half enabled by defining PMU_TX_TDO_CAPTURE_EN.
module pmu_jtag_stream_tx #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned NOP_CYCLES = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  input  logic              abort_i,
`ifdef PMU_TX_TDO_CAPTURE_EN
  input  logic              td_i,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
`endif
  output logic              tms_o,
  output logic              tdi_o,
  output logic              tck_en_o,
  output logic              busy_o,
  output logic              done_o
);

  import pmu_tx_pkg::*;

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] FTR_LAST = CNT_W'(FTR_LEN - 1);
  localparam logic [CNT_W-1:0] NOP_LAST = CNT_W'((NOP_CYCLES == 0) ? 0 : NOP_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_q, wait_d;   // payload underflow stall
  logic             last_q, last_d;   // word in the shifter closes the frame
  logic             done_q, done_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             tck_en_q, tck_en_d;
  logic             busy_q, busy_d;

  logic accept;
  logic shift;
  logic bit_next;
  logic bit_last;

  // Abort wins over a word offered in the same cycle.
  assign word_ready_o = (state_q == StIdle) ||
                        ((state_q == StPayload) && !abort_i && (wait_q || (bit_last && !last_q)));
  assign accept       = word_valid_i && word_ready_o;
  assign shift        = (state_q == StPayload) && !wait_q && !bit_last;

`ifdef PMU_TX_TDO_CAPTURE_EN
  logic cap_en;
  assign cap_en = (state_q == StPayload) && !wait_q;
`endif

  pmu_tx_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .data_i    (word_i),
    .shift_i   (shift),
`ifdef PMU_TX_TDO_CAPTURE_EN
    .cap_en_i  (cap_en),
    .td_i      (td_i),
    .rx_word_o (rx_word_o),
    .rx_valid_o(rx_valid_o),
`endif
    .bit_next_o(bit_next),
    .bit_last_o(bit_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
      tck_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      last_q   <= last_d;
      done_q   <= done_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      tck_en_q <= tck_en_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    last_d  = accept ? word_last_i : last_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHeader;
          cnt_d   = '0;
        end
      end
      StHeader: begin
        if (abort_i) begin
          state_d = StFooter;
          cnt_d   = '0;
        end else if (cnt_q == HDR_LAST) begin
          state_d = StPayload;
          wait_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPayload: begin
        if (abort_i) begin
          state_d = StFooter;
          cnt_d   = '0;
          wait_d  = 1'b0;
        end else if (wait_q) begin
          wait_d = !accept;
        end else if (bit_last) begin
          if (last_q) begin
            state_d = (NOP_CYCLES == 0) ? StFooter : StNop;
            cnt_d   = '0;
          end else begin
            wait_d = !accept;
          end
        end
      end
      StNop: begin
        if (abort_i || (cnt_q == NOP_LAST)) begin
          state_d = StFooter;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFooter: begin
        if (cnt_q == FTR_LAST) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        wait_d  = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    tms_d    = 1'b0;
    tdi_d    = 1'b0;
    tck_en_d = 1'b0;
    busy_d   = (state_d != StIdle);
    case (state_d)
      StHeader: begin
        tms_d    = TMS_HDR[cnt_d[3:0]];
        tdi_d    = TDI_HDR[cnt_d[3:0]];
        tck_en_d = 1'b1;
      end
      StPayload: begin
        tdi_d    = !wait_d && bit_next;
        tck_en_d = !wait_d;
      end
      StNop: begin
        tck_en_d = 1'b1;
      end
      StFooter: begin
        tms_d    = TMS_FTR[cnt_d[2:0]];
        tck_en_d = 1'b1;
      end
      default: begin
        tck_en_d = 1'b0;
      end
    endcase
  end

  assign tms_o    = tms_q;
  assign tdi_o    = tdi_q;
  assign tck_en_o = tck_en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
